// File: rtl/cache_line_writer.sv
// cache_line_writer
//   Builds the 512-bit line written into one way of the 2-way data cache.
//   There are two sources for the line:
//     - A store hit. The store word is byte-merged into the current line of
//       the way that hit.
//     - A refill. Sixteen 32-bit return beats are collected from the bus.
//       A pending store can be merged into the critical word.
//
//   Optional feature (macro CACHE_REFILL_WRAP_EN):
//     - When defined, the refill is a critical-word-first wrap burst. The beat
//       counter starts at the missed word index and wraps from 15 to 0.
//     - When undefined, the beat counter starts at word 0.
//
//   Ports:
//     clk, rst               clock; synchronous active-high reset
//     offset                 byte offset of the store or miss; word = offset[5:2]
//     hit                    per-way hit vector ([0]=way1, [1]=way2)
//     st_valid               store-hit request
//     st_pending             refill carries a store to merge
//     st_wdata, st_wstrb     store data and byte strobes
//     way1/2_rdata_reg       current lines of way1 and way2
//     refill_start           pulse that begins a refill
//     victim_way             refill target (0=way1, 1=way2)
//     ret_valid/data/last    return beat from the bus
//     ret_ready              beat accept; high only while filling
//     busy                   FSM not idle
//     way_we                 one-cycle line write enable per way
//     line_wdata             line write data; holds its value between writes
//     crit_valid/crit_data   raw critical word, one cycle after it arrives
//     refill_done            refill line is being written this cycle
//     fill_err               ret_last arrived before the 16th beat
//
//   Handshake: a return beat transfers on a cycle where ret_valid and
//   ret_ready are both high. ret_ready depends only on state, never on
//   ret_valid. st_valid and refill_start are sampled only in IDLE. While
//   busy is high, upstream holds these requests.
module cache_line_writer #(
    parameter int Offset_len    = 6,
    parameter int Segment_width = 32,
    parameter int Line_width    = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [Offset_len-1:0]      offset,
    input  logic [1:0]                 hit,
    input  logic                       st_valid,
    input  logic                       st_pending,
    input  logic [Segment_width-1:0]   st_wdata,
    input  logic [Segment_width/8-1:0] st_wstrb,
    input  logic [Line_width-1:0]      way1_rdata_reg,
    input  logic [Line_width-1:0]      way2_rdata_reg,
    input  logic                       refill_start,
    input  logic                       victim_way,
    input  logic                       ret_valid,
    input  logic [Segment_width-1:0]   ret_data,
    input  logic                       ret_last,
    output logic                       ret_ready,
    output logic                       busy,
    output logic [1:0]                 way_we,
    output logic [Line_width-1:0]      line_wdata,
    output logic                       crit_valid,
    output logic [Segment_width-1:0]   crit_data,
    output logic                       refill_done,
    output logic                       fill_err
);

    localparam int Idx_w  = Offset_len - 2;
    localparam int Byte_n = Segment_width / 8;

    typedef enum logic [1:0] {IDLE, HITWR, FILL, WRITE} state_t;

    // The state register is a named signal so that checkers can bind to it.
    state_t                     state;
    logic [Idx_w-1:0]           cnt;
    logic [Idx_w-1:0]           idx;
    logic                       victim;
    logic                       pend;
    logic [Segment_width-1:0]   wdata_q;
    logic [Byte_n-1:0]          wstrb_q;
    logic [Line_width-1:0]      line_buf;

    function automatic logic [Segment_width-1:0] merge_word(
        input logic [Segment_width-1:0] old_w,
        input logic [Segment_width-1:0] new_w,
        input logic [Byte_n-1:0]        strb
    );
        logic [Segment_width-1:0] r;
        r = old_w;
        for (int k = 0; k < Byte_n; k++) begin
            if (strb[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

    logic [Idx_w-1:0]         idx_in;
    logic [Line_width-1:0]    hit_line;
    logic [Line_width-1:0]    hit_merged;
    logic                     beat_accept;
    logic [Segment_width-1:0] beat_word;
    logic [Line_width-1:0]    buf_next;
    logic [Idx_w-1:0]         end_idx;
    logic [Idx_w-1:0]         cnt_start;
    logic                     fill_end;

    assign idx_in = offset[Offset_len-1:2];

`ifdef CACHE_REFILL_WRAP_EN
    // In a wrap burst, the 16th beat lands in the word just before the start.
    assign cnt_start = idx_in;
    assign end_idx   = idx - Idx_w'(1);
`else
    assign cnt_start = '0;
    assign end_idx   = '1;
`endif

    assign ret_ready   = (state == FILL);
    assign busy        = (state != IDLE);
    assign beat_accept = (state == FILL) && ret_valid;
    assign fill_end    = beat_accept && ((cnt == end_idx) || ret_last);

    always_comb begin
        // When both ways hit, way1 takes priority.
        hit_line   = hit[0] ? way1_rdata_reg : way2_rdata_reg;
        hit_merged = hit_line;
        hit_merged[int'(idx_in)*Segment_width +: Segment_width] =
            merge_word(hit_line[int'(idx_in)*Segment_width +: Segment_width],
                       st_wdata, st_wstrb);

        beat_word = ret_data;
        if (pend && (cnt == idx)) beat_word = merge_word(ret_data, wdata_q, wstrb_q);
        buf_next = line_buf;
        buf_next[int'(cnt)*Segment_width +: Segment_width] = beat_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            victim      <= 1'b0;
            pend        <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            line_buf    <= '0;
            way_we      <= 2'b00;
            line_wdata  <= '0;
            crit_valid  <= 1'b0;
            crit_data   <= '0;
            refill_done <= 1'b0;
            fill_err    <= 1'b0;
        end else begin
            way_we      <= 2'b00;
            crit_valid  <= 1'b0;
            refill_done <= 1'b0;
            fill_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (refill_start) begin
                        state    <= FILL;
                        idx      <= idx_in;
                        victim   <= victim_way;
                        pend     <= st_pending;
                        wdata_q  <= st_wdata;
                        wstrb_q  <= st_wstrb;
                        line_buf <= '0;
                        cnt      <= cnt_start;
                    end else if (st_valid && (|hit)) begin
                        state      <= HITWR;
                        way_we     <= hit[0] ? 2'b01 : 2'b10;
                        line_wdata <= hit_merged;
                    end
                end
                HITWR: state <= IDLE;
                FILL: begin
                    if (beat_accept) begin
                        line_buf <= buf_next;
                        cnt      <= cnt + Idx_w'(1);
                        // The critical word is reported raw, before any store merge.
                        if (cnt == idx) begin
                            crit_valid <= 1'b1;
                            crit_data  <= ret_data;
                        end
                        // The write data comes from buf_next so the final beat
                        // reaches the line in the same cycle it is accepted.
                        if (fill_end) begin
                            state       <= WRITE;
                            way_we      <= victim ? 2'b10 : 2'b01;
                            line_wdata  <= buf_next;
                            refill_done <= 1'b1;
                            fill_err    <= ret_last && (cnt != end_idx);
                        end
                    end
                end
                WRITE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_writer.sv
// Self-checking bench for cache_line_writer. Expected line writes are pushed
// to a queue when stimulus is driven and compared when way_we pulses.
module tb_cache_line_writer;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   offset;
    logic [1:0]   hit;
    logic         st_valid;
    logic         st_pending;
    logic [31:0]  st_wdata;
    logic [3:0]   st_wstrb;
    logic [511:0] way1_rdata_reg;
    logic [511:0] way2_rdata_reg;
    logic         refill_start;
    logic         victim_way;
    logic         ret_valid;
    logic [31:0]  ret_data;
    logic         ret_last;
    logic         ret_ready;
    logic         busy;
    logic [1:0]   way_we;
    logic [511:0] line_wdata;
    logic         crit_valid;
    logic [31:0]  crit_data;
    logic         refill_done;
    logic         fill_err;

    cache_line_writer dut (
        .clk(clk), .rst(rst), .offset(offset), .hit(hit), .st_valid(st_valid),
        .st_pending(st_pending), .st_wdata(st_wdata), .st_wstrb(st_wstrb),
        .way1_rdata_reg(way1_rdata_reg), .way2_rdata_reg(way2_rdata_reg),
        .refill_start(refill_start), .victim_way(victim_way),
        .ret_valid(ret_valid), .ret_data(ret_data), .ret_last(ret_last),
        .ret_ready(ret_ready), .busy(busy), .way_we(way_we),
        .line_wdata(line_wdata), .crit_valid(crit_valid), .crit_data(crit_data),
        .refill_done(refill_done), .fill_err(fill_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    // entry = {refill_done, way_we, line}
    logic [514:0] exp_q[$];
    logic [31:0]  beat_d[16];

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge_w(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = new_w[8*k +: 8];
        return r;
    endfunction

    // scoreboard: every way_we pulse must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && way_we !== 2'b00) begin
            if (exp_q.size() == 0) begin
                check("we_unexpected", 512'(way_we), 512'(2'b00));
            end else begin
                logic [514:0] e;
                e = exp_q.pop_front();
                check("way_we", 512'(way_we), 512'(e[513:512]));
                check("line", line_wdata, e[511:0]);
                check("refill_done", 512'(refill_done), 512'(e[514]));
            end
        end
    end

    // driver tasks
    task automatic do_store(input logic [1:0] hv, input logic [5:0] off,
                            input logic [31:0] wd, input logic [3:0] strb);
        logic [511:0] expl;
        int w;
        w    = int'(off[5:2]);
        expl = hv[0] ? way1_rdata_reg : way2_rdata_reg;
        if (hv != 2'b00) begin
            expl[w*32 +: 32] = merge_w(expl[w*32 +: 32], wd, strb);
            exp_q.push_back({1'b0, (hv[0] ? 2'b01 : 2'b10), expl});
        end
        st_valid = 1'b1; hit = hv; offset = off; st_wdata = wd; st_wstrb = strb;
        @(posedge clk); #1;
        st_valid = 1'b0; hit = 2'b00;
        check("store_busy", 512'(busy), 512'(hv != 2'b00));
        @(posedge clk); #1;
        check("store_idle", 512'(busy), 512'(1'b0));
    endtask

    task automatic do_refill(input logic vic, input logic [5:0] off, input logic pend,
                             input logic [31:0] wd, input logic [3:0] strb,
                             input int n, input logic last);
        logic [511:0] expl;
        logic [31:0]  w;
        int idx, pos;
        logic done;
        expl = '0;
        idx  = int'(off[5:2]);
        for (int b = 0; b < n; b++) begin
`ifdef CACHE_REFILL_WRAP_EN
            pos = (idx + b) % 16;
`else
            pos = b;
`endif
            w = beat_d[b];
            if (pend && pos == idx) w = merge_w(w, wd, strb);
            expl[pos*32 +: 32] = w;
        end
        done = last || (n == 16);
        if (done) exp_q.push_back({1'b1, (vic ? 2'b10 : 2'b01), expl});

        refill_start = 1'b1; victim_way = vic; offset = off; st_pending = pend;
        st_wdata = wd; st_wstrb = strb;
        @(posedge clk); #1;
        refill_start = 1'b0; st_pending = 1'b0;
        check("fill_ready", 512'(ret_ready), 512'(1'b1));
        check("fill_busy", 512'(busy), 512'(1'b1));
        for (int b = 0; b < n; b++) begin
            ret_valid = 1'b1; ret_data = beat_d[b]; ret_last = last && (b == n - 1);
            @(posedge clk); #1;
`ifdef CACHE_REFILL_WRAP_EN
            pos = (idx + b) % 16;
`else
            pos = b;
`endif
            check("crit_valid", 512'(crit_valid), 512'(pos == idx));
            if (pos == idx) check("crit_data", 512'(crit_data), 512'(beat_d[b]));
        end
        ret_valid = 1'b0; ret_last = 1'b0;
        if (done) begin
            check("done_pulse", 512'(refill_done), 512'(1'b1));
            check("fill_err", 512'(fill_err), 512'(n < 16));
            check("write_ready", 512'(ret_ready), 512'(1'b0));
            @(posedge clk); #1;
            check("after_busy", 512'(busy), 512'(1'b0));
            check("after_ready", 512'(ret_ready), 512'(1'b0));
            check("after_done", 512'(refill_done), 512'(1'b0));
            check("after_err", 512'(fill_err), 512'(1'b0));
        end
    endtask

    initial begin
        rst = 1'b1; offset = '0; hit = '0; st_valid = 0; st_pending = 0;
        st_wdata = '0; st_wstrb = '0; refill_start = 0; victim_way = 0;
        ret_valid = 0; ret_data = '0; ret_last = 0;
        for (int i = 0; i < 16; i++) begin
            way1_rdata_reg[i*32 +: 32] = $urandom;
            way2_rdata_reg[i*32 +: 32] = $urandom;
        end
        way1_rdata_reg[95:64] = 32'h11223344;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_we", 512'(way_we), 512'(2'b00));
        check("rst_line", line_wdata, 512'(0));
        check("rst_busy", 512'(busy), 512'(1'b0));
        check("rst_ready", 512'(ret_ready), 512'(1'b0));

        // directed store hit into way1 word2
        do_store(2'b01, 6'h08, 32'hAABBCCDD, 4'b0011);
        check("tp_word2", 512'(line_wdata[95:64]), 512'(32'h1122CCDD));
        // both ways hit: way1 wins
        do_store(2'b11, 6'h24, 32'h5A5A5A5A, 4'hF);
        // no hit: ignored
        do_store(2'b00, 6'h10, 32'hDEADBEEF, 4'hF);
        // random store hits
        for (int t = 0; t < 8; t++) begin
            do_store(2'($urandom_range(1, 3)), 6'($urandom_range(0, 63)),
                     $urandom, 4'($urandom_range(0, 15)));
        end

        // full refill into way2
        for (int i = 0; i < 16; i++) beat_d[i] = 32'h100 + i;
        do_refill(1'b1, 6'h00, 1'b0, 32'h0, 4'h0, 16, 1'b1);
        // beat offered while idle is not consumed
        ret_valid = 1'b1; ret_data = 32'hFFFF0000;
        @(posedge clk); #1;
        check("idle_ready", 512'(ret_ready), 512'(1'b0));
        check("idle_busy", 512'(busy), 512'(1'b0));
        ret_valid = 1'b0;

        // refill with store merge into word15
        beat_d[15] = 32'h12345678;
        do_refill(1'b0, 6'h3C, 1'b1, 32'hEE000000, 4'b1000, 16, 1'b1);
`ifndef CACHE_REFILL_WRAP_EN
        check("tp_word15", 512'(line_wdata[511:480]), 512'(32'hEE345678));
`endif

        // short burst: last on beat 9
        for (int i = 0; i < 16; i++) beat_d[i] = 32'h200 + i;
        do_refill(1'b0, 6'h00, 1'b0, 32'h0, 4'h0, 10, 1'b1);

        // 16 beats with no ret_last still finish
        for (int i = 0; i < 16; i++) beat_d[i] = $urandom;
        do_refill(1'b1, 6'($urandom_range(0, 63)), 1'b1, $urandom, 4'($urandom_range(0, 15)), 16, 1'b0);

`ifdef CACHE_REFILL_WRAP_EN
        // wrap: word5 first, word4 last
        for (int i = 0; i < 16; i++) beat_d[i] = 32'h300 + i;
        do_refill(1'b0, 6'h14, 1'b0, 32'h0, 4'h0, 16, 1'b1);
        check("wrap_w5", 512'(line_wdata[191:160]), 512'(32'h300));
        check("wrap_w4", 512'(line_wdata[159:128]), 512'(32'h30F));
`endif

        // reset during fill after 5 beats
        for (int i = 0; i < 16; i++) beat_d[i] = 32'h400 + i;
        do_refill(1'b1, 6'h00, 1'b0, 32'h0, 4'h0, 5, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_we", 512'(way_we), 512'(2'b00));
        check("mid_rst_line", line_wdata, 512'(0));
        check("mid_rst_busy", 512'(busy), 512'(1'b0));
        check("mid_rst_ready", 512'(ret_ready), 512'(1'b0));
        check("mid_rst_crit", 512'({crit_valid, crit_data}), 512'(0));
        check("mid_rst_flags", 512'({refill_done, fill_err}), 512'(0));
        repeat (3) @(posedge clk);
        #1;
        do_store(2'b10, 6'h30, 32'hCAFEF00D, 4'b0110);

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", 512'(exp_q.size()), 512'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
